// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: program-memory port, decoder loopback,
// execute-stage handshake, redirect and halt signalling.
interface instruction_fetch_unit_if #(
   parameter int unsigned ADDR_W = 16
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_rdata;
   logic              mem_ready;
   logic [7:0]        ir;
   logic [1:0]        dec_len;
   logic [7:0]        op_lo;
   logic [7:0]        op_hi;
   logic [1:0]        inst_len;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt_in;
   logic              halted;

   modport master (
      output mem_addr, mem_rd, ir, op_lo, op_hi,
      output inst_len, inst_pc, inst_valid, halted,
      input  mem_rdata, mem_ready, dec_len, inst_ready,
      input  redirect_valid, redirect_pc, halt_in
   );

   modport slave (
      input  mem_addr, mem_rd, ir, op_lo, op_hi,
      input  inst_len, inst_pc, inst_valid, halted,
      output mem_rdata, mem_ready, dec_len, inst_ready,
      output redirect_valid, redirect_pc, halt_in
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Byte-serial instruction fetch for the 8-bit MP core: opcode, decoder
// length lookup, 0-2 operand bytes, then valid/ready hand-off.
module instruction_fetch_unit #(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic                      clk,
   input logic                      rst,
   instruction_fetch_unit_if.master bus
);
   typedef enum logic [2:0] {
      F_OP, DECIDE, F_B2, F_B3, HOLD, HALTED
   } state_e;

   localparam logic [ADDR_W-1:0] PC_ONE = 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
   logic [7:0]        ir_q, ir_d;
   logic [7:0]        op_lo_q, op_lo_d;
   logic [7:0]        op_hi_q, op_hi_d;
   logic [1:0]        len_q, len_d;
   logic              fetch_st;
   logic              xfer;

   assign fetch_st = (state_q == F_OP) || (state_q == F_B2) ||
                     (state_q == F_B3);
   assign bus.mem_rd     = fetch_st & ~rst;
   assign xfer           = bus.mem_rd & bus.mem_ready;
   assign bus.mem_addr   = pc_q;
   assign bus.ir         = ir_q;
   assign bus.op_lo      = op_lo_q;
   assign bus.op_hi      = op_hi_q;
   assign bus.inst_len   = len_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.inst_valid = (state_q == HOLD);
   assign bus.halted     = (state_q == HALTED);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_pc_d = inst_pc_q;
      ir_d      = ir_q;
      op_lo_d   = op_lo_q;
      op_hi_d   = op_hi_q;
      len_d     = len_q;
      unique case (state_q)
         F_OP: begin
            if (bus.redirect_valid) begin
               pc_d = bus.redirect_pc;
            end else if (xfer) begin
               ir_d      = bus.mem_rdata;
               inst_pc_d = pc_q;
               op_lo_d   = 8'h00;
               op_hi_d   = 8'h00;
               pc_d      = pc_q + PC_ONE;
               state_d   = DECIDE;
            end
         end
         DECIDE: begin
            if (bus.redirect_valid) begin
               pc_d    = bus.redirect_pc;
               state_d = F_OP;
            end else begin
               len_d   = (bus.dec_len == 2'd0) ? 2'd1 : bus.dec_len;
               state_d = (bus.dec_len < 2'd2) ? HOLD : F_B2;
            end
         end
         F_B2: begin
            if (bus.redirect_valid) begin
               pc_d    = bus.redirect_pc;
               state_d = F_OP;
            end else if (xfer) begin
               op_lo_d = bus.mem_rdata;
               pc_d    = pc_q + PC_ONE;
               state_d = (len_q == 2'd3) ? F_B3 : HOLD;
            end
         end
         F_B3: begin
            if (bus.redirect_valid) begin
               pc_d    = bus.redirect_pc;
               state_d = F_OP;
            end else if (xfer) begin
               op_hi_d = bus.mem_rdata;
               pc_d    = pc_q + PC_ONE;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // A redirect drops the held instruction whether or not it is taken
            if (bus.redirect_valid) begin
               pc_d    = bus.redirect_pc;
               state_d = F_OP;
            end else if (bus.inst_ready) begin
               state_d = bus.halt_in ? HALTED : F_OP;
            end
         end
         HALTED: state_d = HALTED;
         default: state_d = F_OP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= F_OP;
         pc_q      <= RESET_PC;
         inst_pc_q <= RESET_PC;
         ir_q      <= 8'h00;
         op_lo_q   <= 8'h00;
         op_hi_q   <= 8'h00;
         len_q     <= 2'd1;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_pc_q <= inst_pc_d;
         ir_q      <= ir_d;
         op_lo_q   <= op_lo_d;
         op_hi_q   <= op_hi_d;
         len_q     <= len_d;
      end
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: byte memory model, decoder
// length table, and a wrap-around instance with RESET_PC=FFFF.
module tb_instruction_fetch_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   logic [7:0] mem [0:65535];

   always #5 clk = ~clk;

   instruction_fetch_unit_if #(.ADDR_W(16)) b1();
   instruction_fetch_unit_if #(.ADDR_W(16)) b2();

   instruction_fetch_unit #(
      .ADDR_W(16), .RESET_PC(16'h0000)
   ) u_dut (
      .clk(clk), .rst(rst), .bus(b1)
   );

   instruction_fetch_unit #(
      .ADDR_W(16), .RESET_PC(16'hFFFF)
   ) u_wrap (
      .clk(clk), .rst(rst), .bus(b2)
   );

   function automatic logic [1:0] len_of(input logic [7:0] op);
      case (op)
         8'hC3, 8'h32: len_of = 2'd3;
         8'h3E:        len_of = 2'd2;
         8'h00:        len_of = 2'd0;
         default:      len_of = 2'd1;
      endcase
   endfunction

   assign b1.mem_rdata = mem[b1.mem_addr];
   assign b2.mem_rdata = mem[b2.mem_addr];
   assign b1.dec_len   = len_of(b1.ir);
   assign b2.dec_len   = len_of(b2.ir);

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      b1.inst_ready = 1'b0;
      b1.redirect_valid = 1'b0;
      b1.redirect_pc = 16'h0000;
      b1.halt_in = 1'b0;
      b1.mem_ready = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      b2.mem_ready = 1'b1;
      b2.inst_ready = 1'b0;
      b2.redirect_valid = 1'b0;
      b2.redirect_pc = 16'h0000;
      b2.halt_in = 1'b0;

      // reset state
      mem[0] = 8'h3C;
      mem[1] = 8'h00;
      rst = 1'b1;
      b1.inst_ready = 1'b0;
      b1.redirect_valid = 1'b0;
      b1.redirect_pc = 16'h0000;
      b1.halt_in = 1'b0;
      b1.mem_ready = 1'b1;
      step(2);
      @(negedge clk);
      chk("rst_mem_rd", b1.mem_rd, 0);
      chk("rst_valid", b1.inst_valid, 0);
      chk("rst_halted", b1.halted, 0);
      chk("rst_ir", b1.ir, 0);
      chk("rst_len", b1.inst_len, 1);
      chk("rst_inst_pc", b1.inst_pc, 0);
      chk("rst_addr", b1.mem_addr, 0);
      rst = 1'b0;
      #1;
      chk("t1_mem_rd", b1.mem_rd, 1);

      // 1-byte instruction, then zero-length opcode back-to-back
      step(1);
      @(negedge clk);
      chk("t1_valid_early", b1.inst_valid, 0);
      step(1);
      @(negedge clk);
      chk("t1_valid", b1.inst_valid, 1);
      chk("t1_ir", b1.ir, 8'h3C);
      chk("t1_len", b1.inst_len, 1);
      chk("t1_op_lo", b1.op_lo, 0);
      chk("t1_inst_pc", b1.inst_pc, 0);
      chk("t1_addr", b1.mem_addr, 1);
      chk("t1_hold_rd", b1.mem_rd, 0);
      b1.inst_ready = 1'b1;
      step(1);
      b1.inst_ready = 1'b0;
      @(negedge clk);
      chk("t1_acc_valid", b1.inst_valid, 0);
      chk("t1_acc_rd", b1.mem_rd, 1);
      step(2);
      @(negedge clk);
      chk("t1b_valid", b1.inst_valid, 1);
      chk("t1b_ir", b1.ir, 8'h00);
      chk("t1b_len0", b1.inst_len, 1);
      chk("t1b_inst_pc", b1.inst_pc, 1);
      chk("t1b_addr", b1.mem_addr, 2);

      // 3-byte JMP held, accepted with redirect
      mem[0] = 8'hC3; mem[1] = 8'h34; mem[2] = 8'h12;
      do_reset();
      step(3);
      @(negedge clk);
      chk("t2_valid_early", b1.inst_valid, 0);
      step(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_valid", b1.inst_valid, 1);
         chk("t2_bytes", {b1.ir, b1.op_lo, b1.op_hi, 6'd0, b1.inst_len},
             32'hC3_34_12_03);
         chk("t2_addr", b1.mem_addr, 3);
         step(1);
      end
      @(negedge clk);
      b1.inst_ready = 1'b1;
      b1.redirect_valid = 1'b1;
      b1.redirect_pc = 16'h1234;
      step(1);
      b1.inst_ready = 1'b0;
      b1.redirect_valid = 1'b0;
      @(negedge clk);
      chk("t2_redir_addr", b1.mem_addr, 16'h1234);
      chk("t2_redir_valid", b1.inst_valid, 0);

      // 2-byte MVI with two wait cycles per byte
      mem[0] = 8'h3E; mem[1] = 8'h55;
      do_reset();
      b1.mem_ready = 1'b0;
      step(2);
      @(negedge clk);
      chk("t3_wait_addr", b1.mem_addr, 0);
      b1.mem_ready = 1'b1;
      step(1);
      b1.mem_ready = 1'b0;
      step(3);
      @(negedge clk);
      chk("t3_wait2_valid", b1.inst_valid, 0);
      chk("t3_wait2_addr", b1.mem_addr, 1);
      b1.mem_ready = 1'b1;
      step(1);
      @(negedge clk);
      chk("t3_valid", b1.inst_valid, 1);
      chk("t3_op_lo", b1.op_lo, 8'h55);
      chk("t3_len", b1.inst_len, 2);
      chk("t3_pc", b1.mem_addr, 2);

      // flush in F_B2, then redirect in HOLD without ready
      mem[0] = 8'hC3; mem[1] = 8'h34; mem[2] = 8'h12;
      mem[16'h0100] = 8'h3C;
      do_reset();
      step(2);
      b1.redirect_valid = 1'b1;
      b1.redirect_pc = 16'h0100;
      step(1);
      b1.redirect_valid = 1'b0;
      @(negedge clk);
      chk("t4_flush_valid", b1.inst_valid, 0);
      chk("t4_flush_addr", b1.mem_addr, 16'h0100);
      step(1);
      @(negedge clk);
      chk("t4_decide_valid", b1.inst_valid, 0);
      step(1);
      @(negedge clk);
      chk("t4_valid", b1.inst_valid, 1);
      chk("t4_ir", b1.ir, 8'h3C);
      chk("t4_inst_pc", b1.inst_pc, 16'h0100);
      b1.redirect_valid = 1'b1;
      b1.redirect_pc = 16'h0300;
      step(1);
      b1.redirect_valid = 1'b0;
      @(negedge clk);
      chk("t4_drop_valid", b1.inst_valid, 0);
      chk("t4_drop_addr", b1.mem_addr, 16'h0300);

      // 3-byte STA straddling the address wrap
      mem[16'hFFFF] = 8'h32; mem[0] = 8'hAA; mem[1] = 8'hBB;
      do_reset();
      step(4);
      @(negedge clk);
      chk("t5_valid", b2.inst_valid, 1);
      chk("t5_ir", b2.ir, 8'h32);
      chk("t5_op_lo", b2.op_lo, 8'hAA);
      chk("t5_op_hi", b2.op_hi, 8'hBB);
      chk("t5_inst_pc", b2.inst_pc, 16'hFFFF);
      chk("t5_pc", b2.mem_addr, 16'h0002);

      // HLT, redirect ignored, reset resumes
      mem[0] = 8'h76; mem[1] = 8'h3C;
      do_reset();
      step(2);
      @(negedge clk);
      chk("t6_valid", b1.inst_valid, 1);
      b1.inst_ready = 1'b1;
      b1.halt_in = 1'b1;
      step(1);
      b1.inst_ready = 1'b0;
      b1.halt_in = 1'b0;
      @(negedge clk);
      chk("t6_halted", b1.halted, 1);
      chk("t6_mem_rd", b1.mem_rd, 0);
      chk("t6_valid_off", b1.inst_valid, 0);
      b1.redirect_valid = 1'b1;
      b1.redirect_pc = 16'h0200;
      b1.mem_ready = 1'b1;
      step(3);
      b1.redirect_valid = 1'b0;
      @(negedge clk);
      chk("t6_still_halted", b1.halted, 1);
      chk("t6_still_rd", b1.mem_rd, 0);
      chk("t6_addr_kept", b1.mem_addr, 1);
      rst = 1'b1;
      step(1);
      @(negedge clk);
      chk("t6_rst_halted", b1.halted, 0);
      chk("t6_rst_rd", b1.mem_rd, 0);
      rst = 1'b0;
      #1;
      chk("t6_resume_rd", b1.mem_rd, 1);
      chk("t6_resume_addr", b1.mem_addr, 0);
      step(2);
      @(negedge clk);
      chk("t6_resume_valid", b1.inst_valid, 1);
      chk("t6_resume_ir", b1.ir, 8'h76);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
